// File: rtl/ak4619_tdm_target.sv
// Codec-side target of the AK4619 TDM128 link: oversamples bick/lrck/sdin1 on clk,
// deserialises four DAC slots and serialises four ADC slots on sdout1.
module ak4619_tdm_target #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bick,
  input  logic         lrck,
  input  logic         sdin1,
  output logic         sdout1,
  input  logic [W-1:0] adc0,
  input  logic [W-1:0] adc1,
  input  logic [W-1:0] adc2,
  input  logic [W-1:0] adc3,
  output logic [W-1:0] dac0,
  output logic [W-1:0] dac1,
  output logic [W-1:0] dac2,
  output logic [W-1:0] dac3,
  output logic         sample_valid,
  output logic         locked,
  output logic         frame_err
);

  logic [SYNC_STAGES-1:0] bick_sync_r;
  logic [SYNC_STAGES-1:0] lrck_sync_r;
  logic [SYNC_STAGES-1:0] sdin_sync_r;
  logic                   bick_hist_r;
  logic                   lrck_last_rise_r;

  logic [7:0]   bit_cnt_r;
  logic         overrun_r;
  logic         aligned_r;
  logic [1:0]   good_cnt_r;
  logic         locked_r;
  logic         frame_err_r;
  logic         sample_valid_r;
  logic         sdout_r;
  logic [W-1:0] rx_r    [4];
  logic [W-1:0] tx_r    [4];
  logic [W-1:0] dac_r   [4];

  logic         bick_s;
  logic         lrck_s;
  logic         sdin_s;
  logic         rise_s;
  logic         fall_s;
  logic         sync_s;
  logic         in_frame_s;
  logic [1:0]   slot_s;
  logic [4:0]   pos_s;
  logic         tx_bit_s;
  logic [W-1:0] rx_next_s [4];

  assign bick_s     = bick_sync_r[SYNC_STAGES-1];
  assign lrck_s     = lrck_sync_r[SYNC_STAGES-1];
  assign sdin_s     = sdin_sync_r[SYNC_STAGES-1];
  assign rise_s     = bick_s & ~bick_hist_r;
  assign fall_s     = ~bick_s & bick_hist_r;
  assign sync_s     = rise_s & lrck_s & ~lrck_last_rise_r;
  // bit_cnt never exceeds 128, so bit 7 alone marks "outside a frame"
  assign in_frame_s = ~bit_cnt_r[7];
  assign slot_s     = bit_cnt_r[6:5];
  assign pos_s      = bit_cnt_r[4:0];

  assign sdout1       = sdout_r;
  assign dac0         = dac_r[0];
  assign dac1         = dac_r[1];
  assign dac2         = dac_r[2];
  assign dac3         = dac_r[3];
  assign sample_valid = sample_valid_r;
  assign locked       = locked_r;
  assign frame_err    = frame_err_r;

  // Input synchronisers and bick edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bick_sync_r <= {SYNC_STAGES{1'b0}};
      lrck_sync_r <= {SYNC_STAGES{1'b0}};
      sdin_sync_r <= {SYNC_STAGES{1'b0}};
      bick_hist_r <= 1'b0;
    end else begin
      bick_sync_r <= {bick_sync_r[SYNC_STAGES-2:0], bick};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], lrck};
      sdin_sync_r <= {sdin_sync_r[SYNC_STAGES-2:0], sdin1};
      bick_hist_r <= bick_s;
    end
  end

  // Slot bit insertion and transmit bit selection; slot bits below the sample fall out
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rx_next_s[i] = rx_r[i];
    end
    tx_bit_s = 1'b0;
    for (int b = 0; b < W; b++) begin
      if (pos_s == 5'(W - 1 - b)) begin
        rx_next_s[slot_s][b] = sdin_s;
        tx_bit_s             = tx_r[slot_s][b];
      end else begin
        tx_bit_s = tx_bit_s;
      end
    end
  end

  // Frame alignment, receive, lock tracking and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_last_rise_r <= 1'b0;
      bit_cnt_r        <= 8'd128;
      overrun_r        <= 1'b0;
      aligned_r        <= 1'b0;
      good_cnt_r       <= 2'd0;
      locked_r         <= 1'b0;
      frame_err_r      <= 1'b0;
      sample_valid_r   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rx_r[i]  <= {W{1'b0}};
        tx_r[i]  <= {W{1'b0}};
        dac_r[i] <= {W{1'b0}};
      end
    end else begin
      frame_err_r    <= 1'b0;
      sample_valid_r <= 1'b0;
      if (rise_s) begin
        lrck_last_rise_r <= lrck_s;
      end else begin
        lrck_last_rise_r <= lrck_last_rise_r;
      end
      if (sync_s) begin
        bit_cnt_r <= 8'd0;
        overrun_r <= 1'b0;
        aligned_r <= 1'b1;
        tx_r[0]   <= adc0;
        tx_r[1]   <= adc1;
        tx_r[2]   <= adc2;
        tx_r[3]   <= adc3;
        for (int i = 0; i < 4; i++) begin
          rx_r[i] <= {W{1'b0}};
        end
        if ((bit_cnt_r == 8'd128) && !overrun_r) begin
          // The first sync after reset only aligns; it closes no frame
          if (aligned_r) begin
            if (good_cnt_r != 2'd2) begin
              good_cnt_r <= good_cnt_r + 2'd1;
            end else begin
              good_cnt_r <= good_cnt_r;
            end
            if (good_cnt_r != 2'd0) begin
              locked_r <= 1'b1;
            end else begin
              locked_r <= locked_r;
            end
          end else begin
            good_cnt_r <= good_cnt_r;
          end
        end else begin
          frame_err_r <= 1'b1;
          locked_r    <= 1'b0;
          good_cnt_r  <= 2'd0;
        end
      end else if (rise_s) begin
        if (in_frame_s) begin
          bit_cnt_r <= bit_cnt_r + 8'd1;
          for (int i = 0; i < 4; i++) begin
            rx_r[i] <= rx_next_s[i];
          end
          if (bit_cnt_r == 8'd127) begin
            for (int i = 0; i < 4; i++) begin
              dac_r[i] <= rx_next_s[i];
            end
            sample_valid_r <= 1'b1;
          end else begin
            sample_valid_r <= 1'b0;
          end
        end else begin
          overrun_r <= 1'b1;
        end
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Serial output changes only on bick falls and idles low outside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdout_r <= 1'b0;
    end else if (fall_s) begin
      sdout_r <= in_frame_s & tx_bit_s;
    end else begin
      sdout_r <= sdout_r;
    end
  end

endmodule

// File: tb/tb_ak4619_tdm_target.sv
// Directed bench: a behavioural TDM master drives ak4619_tdm_target and checks received
// samples, transmitted slots, lock behaviour and frame error handling.
module tb_ak4619_tdm_target;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bick = 1'b0;
  logic        lrck = 1'b0;
  logic        sdin1 = 1'b0;
  logic        sdout1;
  logic [15:0] adc0 = 16'h0000, adc1 = 16'h0000, adc2 = 16'h0000, adc3 = 16'h0000;
  logic [15:0] dac0, dac1, dac2, dac3;
  logic        sample_valid, locked, frame_err;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  time t_valid = 0;
  time t_last_rise = 0;
  time t_rise = 0;

  logic [15:0] m_dac [4];
  logic [31:0] cap32 [4];
  logic [15:0] adc_new [4];
  logic [15:0] dac_at_sync [4];
  logic        lock_at_sync;
  int          err_at_sync, valid_at_sync, valid_at_128;
  int          abort_at = -1;
  int          adc_chg_at = -1;

  ak4619_tdm_target #(.W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bick(bick), .lrck(lrck), .sdin1(sdin1), .sdout1(sdout1),
    .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3),
    .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
    .sample_valid(sample_valid), .locked(locked), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sample_valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      t_valid   <= $time;
    end
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  // One bick period: low phase presents lrck/sdin, sdout sampled just before the rise
  task automatic bick_cycle(input logic ld, input logic sd, output logic so);
    lrck  = ld;
    sdin1 = sd;
    repeat (HALF) @(posedge clk);
    #1;
    so          = sdout1;
    bick        = 1'b1;
    t_last_rise = $time;
    repeat (HALF) @(posedge clk);
    #1;
    bick = 1'b0;
  endtask

  task automatic send_sync();
    logic so;
    bick_cycle(1'b1, 1'b0, so);
    lock_at_sync   = locked;
    err_at_sync    = err_cnt;
    valid_at_sync  = valid_cnt;
    dac_at_sync[0] = dac0;
    dac_at_sync[1] = dac1;
    dac_at_sync[2] = dac2;
    dac_at_sync[3] = dac3;
  endtask

  task automatic run_frame(input int nbits);
    logic       so, d;
    logic [1:0] s2;
    logic [4:0] b5;
    send_sync();
    for (int j = 0; j < nbits; j++) begin
      if (j == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      if (j == adc_chg_at) begin
        adc0 = adc_new[0]; adc1 = adc_new[1]; adc2 = adc_new[2]; adc3 = adc_new[3];
      end
      s2 = j[6:5];
      b5 = j[4:0];
      d  = (j < 128 && b5 < 5'd16) ? m_dac[s2][4'd15 - b5[3:0]] : 1'b0;
      bick_cycle(1'b0, d, so);
      if (j < 128) cap32[s2][5'd31 - b5] = so;
      if (j == 127) begin
        t_rise       = t_last_rise;
        valid_at_128 = valid_cnt;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bick = 1'b0; lrck = 1'b0; sdin1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_dac(input logic [15:0] a, b, c, e);
    m_dac[0] = a; m_dac[1] = b; m_dac[2] = c; m_dac[3] = e;
  endtask

  task automatic test_reset();
    logic any_dac = 1'b0, any_out = 1'b0, any_valid = 1'b0, any_lock = 1'b0, any_err = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bick = i[0]; lrck = i[1]; sdin1 = i[2];
      repeat (4) @(posedge clk);
      #1;
      any_dac   = any_dac | (|{dac0, dac1, dac2, dac3});
      any_out   = any_out | sdout1;
      any_valid = any_valid | sample_valid;
      any_lock  = any_lock | locked;
      any_err   = any_err | frame_err;
    end
    tests++; if (any_dac !== 1'b0) begin fails++; $display("FAIL reset_dac got=%b want=0", any_dac); end
    tests++; if (any_out !== 1'b0) begin fails++; $display("FAIL reset_sdout got=%b want=0", any_out); end
    tests++; if (any_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", any_valid); end
    tests++; if (any_lock !== 1'b0) begin fails++; $display("FAIL reset_locked got=%b want=0", any_lock); end
    tests++; if (any_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", any_err); end
    bick = 1'b0; lrck = 1'b0; sdin1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (sdout1 !== 1'b0) begin fails++; $display("FAIL release_sdout got=%b want=0", sdout1); end
    tests++; if (valid_cnt !== 0) begin fails++; $display("FAIL release_valid got=%0d want=0", valid_cnt); end
  endtask

  task automatic test_nominal();
    int v0, e0;
    do_reset();
    set_dac(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(128);
    tests++; if (dac0 !== 16'h1234) begin fails++; $display("FAIL nom_dac0 got=%h want=1234", dac0); end
    tests++; if (dac1 !== 16'h8000) begin fails++; $display("FAIL nom_dac1 got=%h want=8000", dac1); end
    tests++; if (dac2 !== 16'h7FFF) begin fails++; $display("FAIL nom_dac2 got=%h want=7fff", dac2); end
    tests++; if (dac3 !== 16'hFFFF) begin fails++; $display("FAIL nom_dac3 got=%h want=ffff", dac3); end
    tests++; if (t_valid < t_rise || (t_valid - t_rise) > 40) begin
      fails++; $display("FAIL nom_valid_window got=%0t want<=40 after rise", t_valid - t_rise);
    end
    send_sync();
    tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL nom_valid_count got=%0d want=1", valid_cnt - v0); end
    tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL nom_err got=%0d want=0", err_cnt - e0); end
  endtask

  task automatic test_transmit();
    logic [15:0] a_old [4];
    a_old[0] = 16'hA5A5; a_old[1] = 16'h0001; a_old[2] = 16'h8000; a_old[3] = 16'h7FFE;
    adc_new[0] = 16'h1111; adc_new[1] = 16'h2222; adc_new[2] = 16'h3333; adc_new[3] = 16'h4444;
    do_reset();
    set_dac(16'h0F0F, 16'h00FF, 16'hF000, 16'h000F);
    adc0 = a_old[0]; adc1 = a_old[1]; adc2 = a_old[2]; adc3 = a_old[3];
    adc_chg_at = 50;
    run_frame(128);
    adc_chg_at = -1;
    for (int n = 0; n < 4; n++) begin
      tests++;
      if (cap32[n] !== {a_old[n], 16'h0000}) begin
        fails++; $display("FAIL tx_slot%0d got=%h want=%h", n, cap32[n], {a_old[n], 16'h0000});
      end
    end
    run_frame(128);
    for (int n = 0; n < 4; n++) begin
      tests++;
      if (cap32[n] !== {adc_new[n], 16'h0000}) begin
        fails++; $display("FAIL tx_next_slot%0d got=%h want=%h", n, cap32[n], {adc_new[n], 16'h0000});
      end
    end
    send_sync();
  endtask

  task automatic test_lock();
    logic l [4];
    int   v0, e0;
    do_reset();
    set_dac(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    v0 = valid_cnt; e0 = err_cnt;
    run_frame(128); l[0] = lock_at_sync;
    run_frame(128); l[1] = lock_at_sync;
    run_frame(128); l[2] = lock_at_sync;
    send_sync();    l[3] = lock_at_sync;
    tests++; if (l[0] !== 1'b0) begin fails++; $display("FAIL lock_sync1 got=%b want=0", l[0]); end
    tests++; if (l[1] !== 1'b0) begin fails++; $display("FAIL lock_sync2 got=%b want=0", l[1]); end
    tests++; if (l[2] !== 1'b1) begin fails++; $display("FAIL lock_sync3 got=%b want=1", l[2]); end
    tests++; if (l[3] !== 1'b1) begin fails++; $display("FAIL lock_sync4 got=%b want=1", l[3]); end
    tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL lock_err got=%0d want=0", err_cnt - e0); end
    tests++; if (valid_cnt - v0 !== 3) begin fails++; $display("FAIL lock_valids got=%0d want=3", valid_cnt - v0); end
  endtask

  task automatic test_short_long();
    int v_s, e_s, e5;
    do_reset();
    set_dac(16'hAAAA, 16'h5555, 16'h1357, 16'h2468);
    run_frame(128); run_frame(128); run_frame(128);
    tests++; if (lock_at_sync !== 1'b1) begin fails++; $display("FAIL sl_locked got=%b want=1", lock_at_sync); end
    set_dac(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
    v_s = valid_cnt; e_s = err_cnt;
    run_frame(100);
    set_dac(16'h0BAD, 16'h1CE0, 16'h2222, 16'h3333);
    run_frame(140);
    e5 = err_at_sync;
    tests++; if (e5 - e_s !== 1) begin fails++; $display("FAIL short_err got=%0d want=1", e5 - e_s); end
    tests++; if (lock_at_sync !== 1'b0) begin fails++; $display("FAIL short_locked got=%b want=0", lock_at_sync); end
    tests++; if (valid_at_sync - v_s !== 0) begin fails++; $display("FAIL short_valid got=%0d want=0", valid_at_sync - v_s); end
    tests++; if (dac_at_sync[0] !== 16'hAAAA || dac_at_sync[3] !== 16'h2468) begin
      fails++; $display("FAIL short_hold got=%h/%h want=aaaa/2468", dac_at_sync[0], dac_at_sync[3]);
    end
    tests++; if (valid_at_128 - v_s !== 1) begin fails++; $display("FAIL long_valid128 got=%0d want=1", valid_at_128 - v_s); end
    tests++; if (valid_cnt - v_s !== 1) begin fails++; $display("FAIL long_valid_total got=%0d want=1", valid_cnt - v_s); end
    tests++; if (dac0 !== 16'h0BAD || dac1 !== 16'h1CE0) begin
      fails++; $display("FAIL long_dac got=%h/%h want=0bad/1ce0", dac0, dac1);
    end
    send_sync();
    tests++; if (err_at_sync - e5 !== 1) begin fails++; $display("FAIL long_err got=%0d want=1", err_at_sync - e5); end
    tests++; if (lock_at_sync !== 1'b0) begin fails++; $display("FAIL long_locked got=%b want=0", lock_at_sync); end
  endtask

  task automatic test_reset_mid();
    int  v0;
    logic l2, l3;
    do_reset();
    set_dac(16'h4321, 16'h8765, 16'h0FED, 16'hCBA9);
    run_frame(128);
    set_dac(16'h6666, 16'h7777, 16'h9999, 16'h1001);
    abort_at = 60;
    v0 = valid_cnt;
    run_frame(128);
    abort_at = -1;
    repeat (6) @(posedge clk);
    #1;
    tests++; if (dac0 !== 16'h0000 || locked !== 1'b0) begin
      fails++; $display("FAIL mid_reset_state got=%h/%b want=0000/0", dac0, locked);
    end
    bick = 1'b0; lrck = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++; if (valid_cnt !== v0) begin fails++; $display("FAIL mid_no_valid got=%0d want=%0d", valid_cnt, v0); end
    run_frame(128);
    run_frame(128); l2 = lock_at_sync;
    run_frame(128); l3 = lock_at_sync;
    send_sync();
    tests++; if (l2 !== 1'b0) begin fails++; $display("FAIL mid_lock_sync2 got=%b want=0", l2); end
    tests++; if (l3 !== 1'b1) begin fails++; $display("FAIL mid_lock_sync3 got=%b want=1", l3); end
    tests++; if (dac2 !== 16'h9999) begin fails++; $display("FAIL mid_dac2 got=%h want=9999", dac2); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_transmit();
    test_lock();
    test_short_long();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
